mac_seq_controller: RTL and testbench

Parametrised successor to the single-pass MAC controller. It sequences the datapath through init, multiply, add and writeback for NUM_ITER iterations, using an internal iteration counter in place of an external finished flag. Multiply and add stages hold for configurable latencies. It exposes busy, done and the current iteration index to the datapath and the top level.

---
 rtl/mac_seq_controller.sv | 144 ++++++++++++++
 tb/tb_mac_seq_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_controller.sv
// Iterating MAC sequencer: INIT, then NUM_ITER rounds of MULT/ADD/WB/CHECK, then a DONE pulse.
// Define MAC_ABORT_EN to add the abort input, which returns any active run to IDLE.
module mac_seq_controller #(
    parameter int NUM_ITER = 4,
    parameter int MULT_LAT = 1,
    parameter int ADD_LAT  = 1,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef MAC_ABORT_EN
    input  logic             abort,
`endif
    output logic             init_w,
    output logic             init_x,
    output logic             load_a,
    output logic             load_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_idx
);

    localparam int STG_MAX = (MULT_LAT > ADD_LAT) ? MULT_LAT : ADD_LAT;
    localparam int STG_W   = (STG_MAX > 1) ? $clog2(STG_MAX) : 1;

    localparam logic [STG_W-1:0] MULT_END  = STG_W'(MULT_LAT - 1);
    localparam logic [STG_W-1:0] ADD_END   = STG_W'(ADD_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MULT,
        S_ADD,
        S_WB,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           ps_q, ps_d;
    logic [STG_W-1:0] stg_q, stg_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic             init_w_q, init_x_q, load_a_q, load_sel_q, busy_q, done_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        ps_d   = ps_q;
        stg_d  = stg_q;
        iter_d = iter_q;
        unique case (ps_q)
            S_IDLE: begin
                stg_d  = '0;
                iter_d = '0;
                if (start) ps_d = S_INIT;
            end
            S_INIT: begin
                if (!start) begin
                    ps_d  = S_MULT;
                    stg_d = '0;
                end
            end
            S_MULT: begin
                if (stg_q == MULT_END) begin
                    ps_d  = S_ADD;
                    stg_d = '0;
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            S_ADD: begin
                if (stg_q == ADD_END) begin
                    ps_d  = S_WB;
                    stg_d = '0;
                end else begin
                    stg_d = stg_q + 1'b1;
                end
            end
            S_WB: ps_d = S_CHECK;
            S_CHECK: begin
                // iter_idx only moves here, so it is stable from MULT through CHECK.
                if (iter_q == LAST_ITER) begin
                    ps_d = S_DONE;
                end else begin
                    ps_d   = S_MULT;
                    stg_d  = '0;
                    iter_d = iter_q + 1'b1;
                end
            end
            S_DONE: begin
                ps_d   = S_IDLE;
                iter_d = '0;
            end
            default: begin
                ps_d   = S_IDLE;
                stg_d  = '0;
                iter_d = '0;
            end
        endcase
`ifdef MAC_ABORT_EN
        // Abort outranks every transition, CHECK->DONE included; in IDLE it is ignored.
        if (abort && ps_q != S_IDLE) begin
            ps_d   = S_IDLE;
            stg_d  = '0;
            iter_d = '0;
        end
`endif
    end

    // Outputs are decoded from the next state and registered, so they track ps_q exactly.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            ps_q       <= S_IDLE;
            stg_q      <= '0;
            iter_q     <= '0;
            init_w_q   <= 1'b0;
            init_x_q   <= 1'b0;
            load_a_q   <= 1'b0;
            load_sel_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            stg_q      <= stg_d;
            iter_q     <= iter_d;
            init_w_q   <= (ps_d == S_INIT);
            init_x_q   <= (ps_d == S_INIT);
            load_a_q   <= (ps_d == S_INIT) || (ps_d == S_WB);
            load_sel_q <= (ps_d == S_WB);
            busy_q     <= (ps_d != S_IDLE);
            done_q     <= (ps_d == S_DONE);
        end
    end

    assign init_w   = init_w_q;
    assign init_x   = init_x_q;
    assign load_a   = load_a_q;
    assign load_sel = load_sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign iter_idx = iter_q;

endmodule

// File: tb/tb_mac_seq_controller.sv
// Bench for mac_seq_controller: a default instance and a NUM_ITER=1/MULT_LAT=3/ADD_LAT=2 instance,
// checked by a scoreboard of expected runs popped on each done pulse.
module tb_mac_seq_controller;

    localparam int A_N = 4, A_M = 1, A_A = 1;
    localparam int B_N = 1, B_M = 3, B_A = 2;

    typedef struct {
        int start_edge;
        int lat;
        int loads;
        int busy_cyc;
        int inits;
        int last_iter;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       abort = 1'b0;
    logic       init_w_a, init_x_a, load_a_a, load_sel_a, busy_a, done_a;
    logic       init_w_b, init_x_b, load_a_b, load_sel_b, busy_b, done_b;
    logic [1:0] iter_a;
    logic [0:0] iter_b;

    int   edge_n  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    mac_seq_controller #(.NUM_ITER(A_N), .MULT_LAT(A_M), .ADD_LAT(A_A), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
`ifdef MAC_ABORT_EN
        .abort(abort),
`endif
        .init_w(init_w_a), .init_x(init_x_a), .load_a(load_a_a), .load_sel(load_sel_a),
        .busy(busy_a), .done(done_a), .iter_idx(iter_a)
    );

    mac_seq_controller #(.NUM_ITER(B_N), .MULT_LAT(B_M), .ADD_LAT(B_A), .CNT_W(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
`ifdef MAC_ABORT_EN
        .abort(abort),
`endif
        .init_w(init_w_b), .init_x(init_x_b), .load_a(load_a_b), .load_sel(load_sel_b),
        .busy(busy_b), .done(done_b), .iter_idx(iter_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Returns 1 ns after the edge numbered k has been counted.
    task automatic wait_after(input int k);
        while (edge_n < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts a run with start held for hold edges; s is the edge that first samples start.
    // Edge counts are inclusive of that edge, so latency equals the number of busy cycles.
    task automatic launch(input int d, input int hold, input bit expect_done, output int s);
        int n, m, a, lat;
        exp_t e;
        n   = (d == 0) ? A_N : B_N;
        m   = (d == 0) ? A_M : B_M;
        a   = (d == 0) ? A_A : B_A;
        s   = edge_n + 1;
        lat = hold + 1 + n * (m + a + 2);
        e   = '{start_edge: s, lat: lat, loads: hold + n, busy_cyc: lat, inits: hold, last_iter: n - 1};
        if (expect_done) begin
            if (d == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
        if (d == 0) start_a = 1'b1;
        else        start_b = 1'b1;
        wait_after(s + hold - 1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", q_a.size() + q_b.size(), 0);
    endtask

    // Monitor: tallies each run while busy and compares against the scoreboard on done.
    logic [1:0] done_v, busy_v, load_v, sel_v, initw_v, initx_v;
    int         iter_v[2];
    assign done_v  = {done_b, done_a};
    assign busy_v  = {busy_b, busy_a};
    assign load_v  = {load_a_b, load_a_a};
    assign sel_v   = {load_sel_b, load_sel_a};
    assign initw_v = {init_w_b, init_w_a};
    assign initx_v = {init_x_b, init_x_a};
    always_comb begin
        iter_v[0] = int'(iter_a);
        iter_v[1] = int'(iter_b);
    end

    initial begin
        int   c_ld[2], c_busy[2], c_init[2], p_iter[2];
        bit   p_busy[2], p_done[2];
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            c_ld[d] = 0; c_busy[d] = 0; c_init[d] = 0; p_iter[d] = 0; p_busy[d] = 0; p_done[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!busy_v[d]) begin
                    c_ld[d] = 0; c_busy[d] = 0; c_init[d] = 0;
                    if (done_v[d]) check($sformatf("d%0d_done_without_busy", d), busy_v[d], 1);
                end else begin
                    c_busy[d]++;
                    if (load_v[d])  c_ld[d]++;
                    if (initw_v[d]) c_init[d]++;
                    check($sformatf("d%0d_init_pair", d), initx_v[d], initw_v[d]);
                    if (load_v[d]) check($sformatf("d%0d_load_sel", d), sel_v[d], !initw_v[d]);
                    if (p_busy[d] && iter_v[d] != p_iter[d])
                        check($sformatf("d%0d_iter_step", d), iter_v[d], p_iter[d] + 1);
                    if (done_v[d]) begin
                        if ((d == 0 ? q_a.size() : q_b.size()) == 0) begin
                            check($sformatf("d%0d_unexpected_done", d), 1, 0);
                        end else begin
                            e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
                            check($sformatf("d%0d_latency", d), edge_n - e.start_edge + 1, e.lat);
                            check($sformatf("d%0d_load_pulses", d), c_ld[d], e.loads);
                            check($sformatf("d%0d_busy_cycles", d), c_busy[d], e.busy_cyc);
                            check($sformatf("d%0d_init_cycles", d), c_init[d], e.inits);
                            check($sformatf("d%0d_last_iter", d), iter_v[d], e.last_iter);
                        end
                    end
                end
                if (p_done[d]) check($sformatf("d%0d_done_width", d), done_v[d], 0);
                p_done[d] = done_v[d];
                p_busy[d] = busy_v[d];
                p_iter[d] = iter_v[d];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        // Reset for two edges; every output must be 0.
        wait_after(2);
        @(negedge clk);
        check("rst_outs_a", {init_w_a, init_x_a, load_a_a, load_sel_a, busy_a, done_a, iter_a}, 0);
        check("rst_outs_b", {init_w_b, init_x_b, load_a_b, load_sel_b, busy_b, done_b, iter_b}, 0);
        wait_after(edge_n + 1);
        rst = 1'b1;
        wait_after(edge_n + 2);

        // Single-cycle start, defaults.
        launch(0, 1, 1'b1, s);
        wait_drain(100);
        wait_after(edge_n + 1);
        @(negedge clk);
        check("idle_iter_cleared", iter_a, 0);

        // start held for three edges.
        wait_after(edge_n + 2);
        launch(0, 3, 1'b1, s);
        wait_drain(100);

        // One iteration with long MULT/ADD stages.
        wait_after(edge_n + 2);
        launch(1, 1, 1'b1, s);
        wait_drain(100);

        // Reset in the ADD cycle of the second iteration.
        wait_after(edge_n + 2);
        launch(0, 1, 1'b0, s);
        wait_after(s + 6);
        @(negedge clk);
        check("pre_rst_busy", busy_a, 1);
        rst = 1'b0;
        wait_after(s + 7);
        @(negedge clk);
        check("midrun_rst_outs", {init_w_a, init_x_a, load_a_a, load_sel_a, busy_a, done_a, iter_a}, 0);
        wait_after(edge_n + 1);
        rst = 1'b1;
        wait_after(edge_n + 3);
        @(negedge clk);
        check("post_rst_idle", busy_a, 0);
        launch(0, 1, 1'b1, s);
        wait_drain(100);

        // start pulses during MULT, CHECK and DONE must not disturb the run.
        wait_after(edge_n + 2);
        launch(0, 1, 1'b1, s);
        wait_after(s + 1);  start_a = 1'b1;
        wait_after(s + 2);  start_a = 1'b0;
        wait_after(s + 4);  start_a = 1'b1;
        wait_after(s + 5);  start_a = 1'b0;
        wait_after(s + 17); start_a = 1'b1;
        wait_after(s + 18); start_a = 1'b0;
        wait_after(s + 20);
        @(negedge clk);
        check("no_restart_busy", busy_a, 0);
        wait_drain(20);

`ifdef MAC_ABORT_EN
        // abort together with start in IDLE is ignored.
        wait_after(edge_n + 2);
        abort = 1'b1;
        launch(0, 1, 1'b1, s);
        abort = 1'b0;
        wait_drain(100);
        // abort in CHECK of the last iteration.
        wait_after(edge_n + 2);
        launch(0, 1, 1'b0, s);
        wait_after(s + 16);
        abort = 1'b1;
        wait_after(s + 17);
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_iter", iter_a, 0);
        wait_after(edge_n + 25);
`endif

        wait_after(edge_n + 5);
        check("sb_empty_a", q_a.size(), 0);
        check("sb_empty_b", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
